// File: rtl/fft_bfly_mem_sequencer.sv
// Radix-2 DIT in-place FFT sequencer. It generates the read addresses for the
// data RAM and the twiddle ROM, registers the butterfly operands and twiddle,
// and writes the butterfly results back to the RAM addresses they were read from.
// The RAM holds the input in bit-reversed order. One butterfly is issued per cycle.
// Optional feature: define FFT_SEQ_CYCLE_CNT_EN to add o_cycle_cnt, a saturating
// count of the cycles spent busy.
module fft_bfly_mem_sequencer #(
  parameter int MAX_LOG2N = 10,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [3:0]             i_log2n,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_rd_en,
  output logic [ADDR_W-1:0]      o_rd_addr_1,
  output logic [ADDR_W-1:0]      o_rd_addr_2,
  input  logic [DATA_W-1:0]      i_rd_data_1,
  input  logic [DATA_W-1:0]      i_rd_data_2,
  output logic [MAX_LOG2N-2:0]   o_tw_addr,
  input  logic [DATA_W-1:0]      i_tw_data,
  output logic                   o_bf_di_valid,
  output logic                   o_bf_w_valid,
  output logic [DATA_W-1:0]      o_bf_di_1,
  output logic [DATA_W-1:0]      o_bf_di_2,
  output logic [DATA_W-1:0]      o_bf_w,
  input  logic                   i_bf_do_valid,
  input  logic [DATA_W-1:0]      i_bf_do_1,
  input  logic [DATA_W-1:0]      i_bf_do_2,
  output logic                   o_wr_en,
  output logic [ADDR_W-1:0]      o_wr_addr_1,
  output logic [ADDR_W-1:0]      o_wr_addr_2,
  output logic [DATA_W-1:0]      o_wr_data_1,
  output logic [DATA_W-1:0]      o_wr_data_2
`ifdef FFT_SEQ_CYCLE_CNT_EN
  ,
  output logic [15:0]            o_cycle_cnt
`endif
);

  localparam int TW_W = MAX_LOG2N - 1;
  localparam int KW   = MAX_LOG2N - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      log2n_q, log2n_d;
  logic [3:0]      s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic [1:0]      dcnt_q, dcnt_d;
  logic            err_d;
  logic            start_ok;
  logic            last_k, last_s;
  logic [KW:0]     half;
  logic [ADDR_W-1:0] k_ext, h, j, g, addr1, addr2;
  logic [TW_W-1:0] tw;
  logic [ADDR_W-1:0] addr1_p1, addr2_p1, addr1_p2, addr2_p2;
  logic            vld_p1;

  // Butterfly index decomposition for the current stage and k, plus end-of-loop flags
  always_comb begin
    k_ext    = ADDR_W'(k_q);
    h        = ADDR_W'(1) << s_q;
    j        = k_ext & (h - ADDR_W'(1));
    g        = k_ext >> s_q;
    addr1    = (g << (s_q + 4'd1)) | j;
    addr2    = addr1 + h;
    tw       = TW_W'(j << (4'(TW_W) - s_q));
    half     = (KW+1)'(1) << (log2n_q - 4'd1);
    last_k   = (({1'b0, k_q} + 1'b1) == half);
    last_s   = (s_q == (log2n_q - 4'd1));
    start_ok = (i_log2n != 4'd0) && (i_log2n <= 4'(MAX_LOG2N));
  end

  // Control state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      log2n_q <= '0;
      s_q     <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      log2n_q <= log2n_d;
      s_q     <= s_d;
      k_q     <= k_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic: run all k of a stage, wait 3 cycles so the last write lands, then continue
  always_comb begin
    state_d = state_q;
    log2n_d = log2n_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (start_ok) begin
            state_d = RUN;
            log2n_d = i_log2n;
            s_d     = '0;
            k_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (last_k) begin
          state_d = DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == 2'd2) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + 4'd1;
          end
        end else begin
          dcnt_d = dcnt_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read issue -> RAM latency -> butterfly operand registers -> write-back registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_en       <= 1'b0;
      o_rd_addr_1   <= '0;
      o_rd_addr_2   <= '0;
      o_tw_addr     <= '0;
      vld_p1        <= 1'b0;
      addr1_p1      <= '0;
      addr2_p1      <= '0;
      o_bf_di_valid <= 1'b0;
      o_bf_w_valid  <= 1'b0;
      o_bf_di_1     <= '0;
      o_bf_di_2     <= '0;
      o_bf_w        <= '0;
      addr1_p2      <= '0;
      addr2_p2      <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr_1   <= '0;
      o_wr_addr_2   <= '0;
      o_wr_data_1   <= '0;
      o_wr_data_2   <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_rd_en <= (state_q == RUN);
      if (state_q == RUN) begin
        o_rd_addr_1 <= addr1;
        o_rd_addr_2 <= addr2;
        o_tw_addr   <= tw;
      end
      vld_p1        <= o_rd_en;
      addr1_p1      <= o_rd_addr_1;
      addr2_p1      <= o_rd_addr_2;
      o_bf_di_valid <= vld_p1;
      o_bf_w_valid  <= vld_p1;
      o_bf_di_1     <= i_rd_data_1;
      o_bf_di_2     <= i_rd_data_2;
      o_bf_w        <= i_tw_data;
      addr1_p2      <= addr1_p1;
      addr2_p2      <= addr2_p1;
      o_wr_en       <= o_bf_di_valid && i_bf_do_valid;
      o_wr_addr_1   <= addr1_p2;
      o_wr_addr_2   <= addr2_p2;
      o_wr_data_1   <= i_bf_do_1;
      o_wr_data_2   <= i_bf_do_2;
      o_busy        <= (state_d != IDLE);
      o_done        <= (state_q == DONE);
      o_err         <= err_d;
    end
  end

`ifdef FFT_SEQ_CYCLE_CNT_EN
  // Busy-cycle counter: cleared on accepted start, saturating, holds after completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cycle_cnt <= '0;
    end else if ((state_q == IDLE) && i_start && start_ok) begin
      o_cycle_cnt <= '0;
    end else if (o_busy && (o_cycle_cnt != 16'hFFFF)) begin
      o_cycle_cnt <= o_cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bfly_mem_sequencer.sv
// Directed testbench for fft_bfly_mem_sequencer, with a behavioural RAM,
// a twiddle ROM and a scaled Q1.15 butterfly model.
module tb_fft_bfly_mem_sequencer;
  localparam int MAX_LOG2N = 10;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] log2n = 4'd0;
  logic busy, done, err, rd_en, bf_di_valid, bf_w_valid, wr_en;
  logic [ADDR_W-1:0] rd_addr_1, rd_addr_2, wr_addr_1, wr_addr_2;
  logic [MAX_LOG2N-2:0] tw_addr;
  logic [DATA_W-1:0] rd_data_1 = '0, rd_data_2 = '0, tw_data = '0;
  logic [DATA_W-1:0] bf_di_1, bf_di_2, bf_w, bf_do_1, bf_do_2, wr_data_1, wr_data_2;
  logic bf_ok = 1'b1;
  logic bf_do_valid;
`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  logic [DATA_W-1:0] mem [1<<ADDR_W];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [MAX_LOG2N-2:0] a);
    return {7'd0, a, 16'h7FFF};
  endfunction

  function automatic logic [31:0] bfly(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] w, input bit upper);
    logic signed [31:0] ar, ai, br, bi, wr, wi, pr, pi, yr, yi;
    ar = {{16{a[31]}}, a[31:16]};  ai = {{16{a[15]}}, a[15:0]};
    br = {{16{b[31]}}, b[31:16]};  bi = {{16{b[15]}}, b[15:0]};
    wr = {{16{w[31]}}, w[31:16]};  wi = {{16{w[15]}}, w[15:0]};
    pr = (wr * br - wi * bi) >>> 15;
    pi = (wr * bi + wi * br) >>> 15;
    yr = upper ? (ar + pr) >>> 1 : (ar - pr) >>> 1;
    yi = upper ? (ai + pi) >>> 1 : (ai - pi) >>> 1;
    return {yr[15:0], yi[15:0]};
  endfunction

  assign bf_do_1     = bfly(bf_di_1, bf_di_2, bf_w, 1'b1);
  assign bf_do_2     = bfly(bf_di_1, bf_di_2, bf_w, 1'b0);
  assign bf_do_valid = bf_di_valid & bf_ok;

  // RAM and ROM with one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_1 <= mem[rd_addr_1];
      rd_data_2 <= mem[rd_addr_2];
      tw_data   <= rom(tw_addr);
    end
    if (wr_en) begin
      mem[wr_addr_1] <= wr_data_1;
      mem[wr_addr_2] <= wr_data_2;
    end
  end

  fft_bfly_mem_sequencer #(.MAX_LOG2N(MAX_LOG2N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_log2n(log2n),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_rd_en(rd_en), .o_rd_addr_1(rd_addr_1), .o_rd_addr_2(rd_addr_2),
    .i_rd_data_1(rd_data_1), .i_rd_data_2(rd_data_2),
    .o_tw_addr(tw_addr), .i_tw_data(tw_data),
    .o_bf_di_valid(bf_di_valid), .o_bf_w_valid(bf_w_valid),
    .o_bf_di_1(bf_di_1), .o_bf_di_2(bf_di_2), .o_bf_w(bf_w),
    .i_bf_do_valid(bf_do_valid), .i_bf_do_1(bf_do_1), .i_bf_do_2(bf_do_2),
    .o_wr_en(wr_en), .o_wr_addr_1(wr_addr_1), .o_wr_addr_2(wr_addr_2),
    .o_wr_data_1(wr_data_1), .o_wr_data_2(wr_data_2)
`ifdef FFT_SEQ_CYCLE_CNT_EN
    , .o_cycle_cnt(cycle_cnt)
`endif
  );

  // Start pulse; returns #1 after the accepting edge (cycle 0)
  task automatic do_start(input logic [3:0] l);
    @(negedge clk);
    start = 1'b1;
    log2n = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tot_cnt++;
    if ({busy, done, err, rd_en, bf_di_valid, bf_w_valid, wr_en} !== 7'd0)
      $display("FAIL reset_ctrl got %b want 0", {busy, done, err, rd_en, bf_di_valid, bf_w_valid, wr_en});
    else pass_cnt++;
    tot_cnt++;
    if ({rd_addr_1, rd_addr_2, tw_addr, wr_addr_1, wr_addr_2} !== '0)
      $display("FAIL reset_addr got %h want 0", {rd_addr_1, rd_addr_2, tw_addr, wr_addr_1, wr_addr_2});
    else pass_cnt++;
    tot_cnt++;
    if ({bf_di_1, bf_di_2, bf_w, wr_data_1, wr_data_2} !== '0)
      $display("FAIL reset_data got %h want 0", {bf_di_1, bf_di_2, bf_w, wr_data_1, wr_data_2});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_log2n2;
    logic [5:0] exp_ctl [12];
    logic [5:0] ctl;
    exp_ctl = '{6'b000010, 6'b100010, 6'b100010, 6'b011010, 6'b011110, 6'b000110,
                6'b100010, 6'b100010, 6'b011010, 6'b011110, 6'b000110, 6'b000001};
    mem[0] = 32'h1000_0000; mem[1] = 32'h0800_0000;
    mem[2] = 32'h0400_0000; mem[3] = 32'h0200_0000;
    do_start(4'd2);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      ctl = {rd_en, bf_di_valid, bf_w_valid, wr_en, busy, done};
      tot_cnt++;
      if (ctl !== exp_ctl[c])
        $display("FAIL n4_ctl cycle %0d got %b want %b", c, ctl, exp_ctl[c]);
      else pass_cnt++;
      if (c == 1 || c == 2 || c == 6 || c == 7) begin
        logic [29:0] exp_rd;
        case (c)
          1:       exp_rd = {10'd0, 10'd1, 10'd0};
          2:       exp_rd = {10'd2, 10'd3, 10'd0};
          6:       exp_rd = {10'd0, 10'd2, 10'd0};
          default: exp_rd = {10'd1, 10'd3, 10'd256};
        endcase
        tot_cnt++;
        if ({rd_addr_1, rd_addr_2, 1'b0, tw_addr} !== exp_rd)
          $display("FAIL n4_rd cycle %0d got %0d,%0d,tw%0d want %h", c, rd_addr_1, rd_addr_2, tw_addr, exp_rd);
        else pass_cnt++;
      end
      if (c == 4 || c == 5 || c == 9 || c == 10) begin
        logic [19:0] exp_wr;
        case (c)
          4:       exp_wr = {10'd0, 10'd1};
          5:       exp_wr = {10'd2, 10'd3};
          9:       exp_wr = {10'd0, 10'd2};
          default: exp_wr = {10'd1, 10'd3};
        endcase
        tot_cnt++;
        if ({wr_addr_1, wr_addr_2} !== exp_wr)
          $display("FAIL n4_wr cycle %0d got %0d,%0d want %h", c, wr_addr_1, wr_addr_2, exp_wr);
        else pass_cnt++;
      end
      if (c == 3) begin
        tot_cnt++;
        if ({bf_di_1, bf_di_2, bf_w} !== {32'h1000_0000, 32'h0800_0000, rom(9'd0)})
          $display("FAIL n4_bf_ops got %h %h %h", bf_di_1, bf_di_2, bf_w);
        else pass_cnt++;
      end
      if (c == 4) begin
        tot_cnt++;
        if ({wr_data_1, wr_data_2} !== {bfly(32'h1000_0000, 32'h0800_0000, rom(9'd0), 1'b1),
                                         bfly(32'h1000_0000, 32'h0800_0000, rom(9'd0), 1'b0)})
          $display("FAIL n4_wr_data got %h %h", wr_data_1, wr_data_2);
        else pass_cnt++;
      end
      if (c == 9) begin
        tot_cnt++;
        if (bf_w !== rom(9'd256))
          $display("FAIL n4_bf_tw256 got %h want %h", bf_w, rom(9'd256));
        else pass_cnt++;
      end
    end
    @(posedge clk);
    #1;
    tot_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL n4_done_pulse got %b want 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_impulse;
    int c;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[0] = 32'h4000_0000;
    do_start(4'd3);
    c = 0;
    while (!done && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    tot_cnt++;
    if (c !== 22) $display("FAIL n8_latency got %0d want 22", c);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      tot_cnt++;
      if (mem[i] !== 32'h0800_0000) $display("FAIL n8_out[%0d] got %h want 08000000", i, mem[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal(input logic [3:0] l);
    int rd_seen;
    do_start(l);
    tot_cnt++;
    if ({err, busy} !== 2'b10) $display("FAIL illegal%0d_err got %b want 10", l, {err, busy});
    else pass_cnt++;
    rd_seen = 0;
    for (int c = 1; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (rd_en || busy || err) rd_seen++;
    end
    tot_cnt++;
    if (rd_seen !== 0) $display("FAIL illegal%0d_quiet got %0d active cycles want 0", l, rd_seen);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    int first, ndone;
    first = -1;
    ndone = 0;
    do_start(4'd4);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = c;
      end
      if (c == 10) begin
        start = 1'b1;
        log2n = 4'd2;
      end
      if (c == 11) start = 1'b0;
    end
    tot_cnt++;
    if (first !== 45) $display("FAIL busy_start_latency got %0d want 45", first);
    else pass_cnt++;
    tot_cnt++;
    if (ndone !== 1) $display("FAIL busy_start_ndone got %0d want 1", ndone);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    do_start(4'd3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tot_cnt++;
    if ({busy, rd_en, bf_di_valid, wr_en, rd_addr_1, rd_addr_2, tw_addr} !== '0)
      $display("FAIL midreset_out got %h want 0", {busy, rd_en, bf_di_valid, wr_en, rd_addr_1, rd_addr_2, tw_addr});
    else pass_cnt++;
    tot_cnt++;
    if ({bf_di_1, wr_data_1, done} !== '0)
      $display("FAIL midreset_data got %h want 0", {bf_di_1, wr_data_1, done});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_log2n2();
  endtask

  task automatic test_wr_suppress;
    int wr_seen;
    bf_ok = 1'b0;
    wr_seen = 0;
    do_start(4'd2);
    for (int c = 1; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (wr_en) wr_seen++;
    end
    tot_cnt++;
    if (wr_seen !== 0) $display("FAIL wr_suppress got %0d writes want 0", wr_seen);
    else pass_cnt++;
    tot_cnt++;
    if (done !== 1'b1) $display("FAIL wr_suppress_done got %b want 1", done);
    else pass_cnt++;
    bf_ok = 1'b1;
  endtask

`ifdef FFT_SEQ_CYCLE_CNT_EN
  task automatic test_cycle_cnt;
    int c;
    do_start(4'd10);
    c = 0;
    while (!done && c < 6000) begin
      @(posedge clk);
      #1;
      c++;
    end
    tot_cnt++;
    if (cycle_cnt !== 16'd5151) $display("FAIL cycle_cnt got %0d want 5151", cycle_cnt);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    tot_cnt++;
    if (cycle_cnt !== 16'd5151) $display("FAIL cycle_cnt_hold got %0d want 5151", cycle_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    test_reset();
    test_log2n2();
    test_impulse();
    test_illegal(4'd0);
    test_illegal(4'd11);
    test_start_while_busy();
    test_wr_suppress();
    test_reset_mid_run();
`ifdef FFT_SEQ_CYCLE_CNT_EN
    test_cycle_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
